eth_fmc_reset_sequencer: RTL

//  Supervises the Ethernet-FMC MMCM clock generator. Pulses the MMCM reset, waits for lock
//  and qualifies it as stable. Only then releases the reset for the logic clocked by the

---
 rtl/eth_fmc_reset_sequencer_pkg.sv | 25 ++
 rtl/eth_fmc_reset_sequencer_if.sv | 34 +++
 rtl/eth_fmc_reset_sequencer_sync2.sv | 24 ++
 rtl/eth_fmc_reset_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/eth_fmc_reset_sequencer_pkg.sv
// rtl/eth_fmc_reset_sequencer_pkg.sv - state encoding and sizing helpers for the MMCM reset sequencer
package eth_fmc_rstseq_pkg;

  typedef enum logic [2:0] {
    S_MMCM_RST  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  // One extra bit over the largest terminal count keeps the compare values representable.
  function automatic int cnt_width(int rst_pulse, int lock_timeout, int stable);
    int m;
    m = rst_pulse;
    if (lock_timeout > m) m = lock_timeout;
    if (stable > m) m = stable;
    return $clog2(m) + 1;
  endfunction

  function automatic int retry_width(int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/eth_fmc_reset_sequencer_if.sv
// rtl/eth_fmc_reset_sequencer_if.sv - lock/request inputs and reset/status outputs of the sequencer (ETH_FMC_RSTSEQ_STATS_EN adds lock_loss_cnt)
interface eth_fmc_reset_sequencer_if;

  logic mmcm_locked;
  logic sw_rst_req;
  logic mmcm_rst;
  logic rst_out;
  logic ready;
  logic fail;
`ifdef ETH_FMC_RSTSEQ_STATS_EN
  logic [15:0] lock_loss_cnt;

  modport master (
    input  mmcm_locked, sw_rst_req,
    output mmcm_rst, rst_out, ready, fail, lock_loss_cnt
  );

  modport slave (
    output mmcm_locked, sw_rst_req,
    input  mmcm_rst, rst_out, ready, fail, lock_loss_cnt
  );
`else
  modport master (
    input  mmcm_locked, sw_rst_req,
    output mmcm_rst, rst_out, ready, fail
  );

  modport slave (
    output mmcm_locked, sw_rst_req,
    input  mmcm_rst, rst_out, ready, fail
  );
`endif

endinterface

// File: rtl/eth_fmc_reset_sequencer_sync2.sv
// rtl/eth_fmc_reset_sequencer_sync2.sv - two-flop synchroniser with synchronous clear
module eth_fmc_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/eth_fmc_reset_sequencer.sv
// rtl/eth_fmc_reset_sequencer.sv - MMCM reset pulse, lock qualification and downstream reset release
// Optional lock-loss statistics counter: ETH_FMC_RSTSEQ_STATS_EN
module eth_fmc_reset_sequencer
  import eth_fmc_rstseq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 8,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int STABLE_CYCLES    = 1024,
  parameter int MAX_RETRIES      = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  eth_fmc_reset_sequencer_if.master   bus
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = retry_width(MAX_RETRIES);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  state_e          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [RW-1:0]   retries, retries_d;
  logic            locked_s;
  logic            mmcm_rst_q, rst_out_q, ready_q, fail_q;

  eth_fmc_sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.mmcm_locked),
    .q     (locked_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_MMCM_RST;
      cnt        <= '0;
      retries    <= '0;
      mmcm_rst_q <= 1'b1;
      rst_out_q  <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      retries    <= retries_d;
      // Decoding the next state makes each registered output track the current state.
      mmcm_rst_q <= (state_d == S_MMCM_RST);
      rst_out_q  <= (state_d != S_RUN);
      ready_q    <= (state_d == S_RUN);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  always_comb begin
    state_d   = state;
    retries_d = retries;
    cnt_d     = cnt;
    if (bus.sw_rst_req) begin
      state_d   = S_MMCM_RST;
      retries_d = '0;
    end else begin
      case (state)
        S_MMCM_RST: begin
          if (cnt == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (cnt == LOCK_LAST) begin
            state_d   = (retries == RETRY_MAX) ? S_FAIL : S_MMCM_RST;
            retries_d = (&retries) ? retries : retries + RW'(1);
          end
        end
        S_STABLE: begin
          // Lock loss takes precedence over completing the stable window.
          if (!locked_s) begin
            state_d = S_MMCM_RST;
          end else if (cnt == STABLE_LAST) begin
            state_d   = S_RUN;
            retries_d = '0;
          end
        end
        S_RUN: begin
          if (!locked_s) state_d = S_MMCM_RST;
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_MMCM_RST;
        end
      endcase
    end

    if (bus.sw_rst_req || (state_d != state)) begin
      cnt_d = '0;
    end else if ((state != S_RUN) && (state != S_FAIL)) begin
      cnt_d = cnt + CW'(1);
    end
  end

  assign bus.mmcm_rst = mmcm_rst_q;
  assign bus.rst_out  = rst_out_q;
  assign bus.ready    = ready_q;
  assign bus.fail     = fail_q;

`ifdef ETH_FMC_RSTSEQ_STATS_EN
  logic [15:0] lock_loss_q;
  logic        loss_evt;

  // Only a genuine lock drop out of RUN counts; software re-sequencing does not.
  assign loss_evt = !bus.sw_rst_req && (state == S_RUN) && !locked_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_loss_q <= '0;
    end else if (loss_evt && (lock_loss_q != 16'hFFFF)) begin
      lock_loss_q <= lock_loss_q + 16'd1;
    end
  end

  assign bus.lock_loss_cnt = lock_loss_q;
`endif

endmodule
